// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with runtime-programmable frame format
//
// Purpose:
//   Accepts bytes over a valid/ready handshake into a circular FIFO. It serialises
//   each byte onto tx_o as one frame: start, 5..8 data bits LSB first, optional
//   parity, and 1 or 2 stop bits. The frame format and the divisor are latched
//   when a byte is popped, so changes in the middle of a frame do not affect it.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   baud_div_i     clocks per bit (values below 4 behave as 4)
//   data_bits_i    0..3 -> 5..8 data bits
//   parity_mode_i  0 none, 1 even, 2 odd, 3 mark
//   stop2_i        0 one stop bit, 1 two stop bits
//   in_data_i      byte to queue (bits above the data length are ignored)
//   in_valid_i     producer has a byte
//   in_ready_o     FIFO can take a byte this cycle
//   tx_o           serial line, idle high
//   busy_o         frame in flight or FIFO non-empty
//   fifo_count_o   FIFO occupancy

module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DIV_WIDTH-1:0]             baud_div_i,
  input  logic [1:0]                       data_bits_i,
  input  logic [1:0]                       parity_mode_i,
  input  logic                             stop2_i,
  input  logic [7:0]                       in_data_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic                             tx_o,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          pop;

  // Transmit engine
  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   timer_q, timer_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;

  // Frame configuration captured at pop time
  logic [DIV_WIDTH-1:0]   cfg_div_q, cfg_div_d;
  logic [1:0]             cfg_dbits_q, cfg_dbits_d;
  logic [1:0]             cfg_pmode_q, cfg_pmode_d;
  logic                   cfg_stop2_q, cfg_stop2_d;

  logic [DIV_WIDTH-1:0]   div_clamped;
  logic [7:0]             data_mask;
  logic                   data_xor;
  logic                   last_data_bit;

  assign div_clamped = (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;

  // ~dbits equals 3 - dbits, the number of unused upper bits to mask off.
  assign data_mask     = 8'hFF >> (~cfg_dbits_q);
  assign data_xor      = ^(shift_q & data_mask);
  assign last_data_bit = (bitcnt_q == (3'd4 + {1'b0, cfg_dbits_q}));

  // in_ready_q always mirrors !full, so an accept can never overflow.
  assign accept = in_valid_i && in_ready_q;

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Registered from the next count so the flags line up with fifo_count_o.
    in_ready_d = (count_d != FULL_CNT);
    busy_d     = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    cfg_div_d   = cfg_div_q;
    cfg_dbits_d = cfg_dbits_q;
    cfg_pmode_d = cfg_pmode_q;
    cfg_stop2_d = cfg_stop2_q;
    pop         = 1'b0;
    tx_d        = 1'b1;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop         = 1'b1;
          shift_d     = mem_q[rd_ptr_q];
          bitcnt_d    = '0;
          stop_cnt_d  = 1'b0;
          cfg_div_d   = div_clamped;
          cfg_dbits_d = data_bits_i;
          cfg_pmode_d = parity_mode_i;
          cfg_stop2_d = stop2_i;
          timer_d     = div_clamped - DIV_WIDTH'(1);
          state_d     = S_START;
        end
      end

      S_START: begin
        tx_d = 1'b0;
        if (timer_q == '0) begin
          // Shift register is still untouched here, so all data bits are visible.
          case (cfg_pmode_q)
            2'd1:    parity_d = data_xor;
            2'd2:    parity_d = ~data_xor;
            2'd3:    parity_d = 1'b1;
            default: parity_d = 1'b0;
          endcase
          timer_d = cfg_div_q - DIV_WIDTH'(1);
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - DIV_WIDTH'(1);
        end
      end

      S_DATA: begin
        tx_d = shift_q[0];
        if (timer_q == '0) begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          timer_d  = cfg_div_q - DIV_WIDTH'(1);
          if (last_data_bit) begin
            state_d = (cfg_pmode_q == 2'd0) ? S_STOP : S_PARITY;
          end
        end else begin
          timer_d = timer_q - DIV_WIDTH'(1);
        end
      end

      S_PARITY: begin
        tx_d = parity_q;
        if (timer_q == '0) begin
          timer_d = cfg_div_q - DIV_WIDTH'(1);
          state_d = S_STOP;
        end else begin
          timer_d = timer_q - DIV_WIDTH'(1);
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (timer_q == '0) begin
          if (cfg_stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            timer_d    = cfg_div_q - DIV_WIDTH'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      stop_cnt_q  <= 1'b0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      cfg_div_q   <= MIN_DIV;
      cfg_dbits_q <= 2'd3;
      cfg_pmode_q <= 2'd0;
      cfg_stop2_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      stop_cnt_q  <= stop_cnt_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      cfg_div_q   <= cfg_div_d;
      cfg_dbits_q <= cfg_dbits_d;
      cfg_pmode_q <= cfg_pmode_d;
      cfg_stop2_q <= cfg_stop2_d;
    end
  end

  // The line is driven from a flop one cycle behind the FSM state, which keeps
  // tx_o glitch-free and isolated from in_data_i.
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign in_ready_o   = in_ready_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .baud_div_i    (baud_div),
    .data_bits_i   (data_bits),
    .parity_mode_i (parity_mode),
    .stop2_i       (stop2),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .tx_o          (tx),
    .busy_o        (busy),
    .fifo_count_o  (fifo_count)
  );

  typedef struct {
    int div;
    int db;
    int pm;
    int s2;
  } cfg_t;

  typedef struct {
    int         div;
    int         db;
    int         pm;
    int         s2;
    logic [7:0] data;
    string      pat;   // line bits in transmit order
    int         eff;   // expected clocks per bit
  } vec_t;

  int checks = 0;
  int fails  = 0;
  int acc_at_full;

  bit         tr[$];
  bit         bq[$];
  bit         rq[$];
  int         cq[$];
  bit         exp_q[$];
  logic [7:0] src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    baud_div    = 16'(c.div);
    data_bits   = 2'(c.db);
    parity_mode = 2'(c.pm);
    stop2       = (c.s2 != 0);
  endtask

  // Reference model: expected per-clock line level for one frame, from the
  // frame rules, followed by the one-clock idle gap unless it is the last frame.
  function automatic void add_frame(input logic [7:0] b, input cfg_t c, input bit last);
    bit bits[$];
    int n;
    int eff;
    int ones;
    n    = c.db + 5;
    eff  = (c.div < 4) ? 4 : c.div;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (c.pm == 1) bits.push_back((ones % 2) == 1);
    if (c.pm == 2) bits.push_back((ones % 2) == 0);
    if (c.pm == 3) bits.push_back(1'b1);
    bits.push_back(1'b1);
    if (c.s2 != 0) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int k = 0; k < eff; k++) exp_q.push_back(bits[j]);
    end
    if (!last) exp_q.push_back(1'b1);
  endfunction

  task automatic produce();
    int   idx;
    int   guard;
    logic rdy;
    idx         = 0;
    guard       = 0;
    acc_at_full = -1;
    @(negedge clk);
    while (idx < src.size() && guard < 40000) begin
      in_valid = 1'b1;
      in_data  = src[idx];
      rdy      = in_ready;
      if (!rdy && acc_at_full < 0) acc_at_full = idx;
      @(posedge clk);
      if (rdy) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (idx < src.size()) check("produce_timeout", 32'(idx), 32'(src.size()));
  endtask

  task automatic capture();
    int low_run;
    bit seen;
    int guard;
    low_run = 0;
    seen    = 1'b0;
    guard   = 0;
    tr.delete(); bq.delete(); rq.delete(); cq.delete();
    while (guard < 60000 && !(seen && low_run >= 20)) begin
      @(negedge clk);
      tr.push_back(tx);
      bq.push_back(busy);
      rq.push_back(in_ready);
      cq.push_back(int'(fifo_count));
      if (busy) begin
        seen    = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      guard++;
    end
    if (!(seen && low_run >= 20)) check("capture_timeout", 32'(guard), 32'd0);
  endtask

  task automatic analyze(input string name);
    int s;
    int bad;
    int bh;
    bit e;
    s   = -1;
    bad = 0;
    bh  = 0;
    foreach (tr[i]) if (s < 0 && tr[i] == 1'b0) s = i;
    // Sample 0 precedes the accept edge, so the start bit shows at sample 3.
    check({name, "_latency"}, 32'(s), 32'd3);
    if (s >= 0) begin
      if (tr.size() - s < exp_q.size()) bad += exp_q.size() - (tr.size() - s);
      for (int i = s; i < tr.size(); i++) begin
        e = (i - s < exp_q.size()) ? exp_q[i - s] : 1'b1;
        if (tr[i] != e) bad++;
      end
    end else begin
      bad = exp_q.size();
    end
    check({name, "_wave_errs"}, 32'(bad), 32'd0);
    foreach (bq[i]) if (bq[i]) bh++;
    check({name, "_busy_clks"}, 32'(bh), 32'(exp_q.size() + 1));
  endtask

  task automatic run_burst(input string name, input int change_at, input cfg_t newc);
    fork
      produce();
      capture();
      begin
        if (change_at > 0) begin
          repeat (change_at) @(negedge clk);
          apply_cfg(newc);
        end
      end
    join
    analyze(name);
  endtask

  vec_t vecs[6];
  cfg_t none_c;

  initial begin
    cfg_t c;
    cfg_t c2;
    int   n;
    int   first0;
    int   stretch;
    int   maxc;
    int   badc;
    int   zeros;
    int   bhi;

    vecs[0] = '{434, 3, 0, 0, 8'h55, "0101010101",  434};
    vecs[1] = '{16,  2, 1, 1, 8'hA3, "01100010111", 16};
    vecs[2] = '{8,   0, 2, 0, 8'hFF, "01111101",    8};
    vecs[3] = '{8,   1, 3, 0, 8'h00, "000000011",   8};
    vecs[4] = '{1,   3, 0, 0, 8'h3C, "0001111001",  4};
    vecs[5] = '{5,   0, 1, 1, 8'hE1, "010000111",   5};
    none_c  = '{4, 3, 0, 0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    apply_cfg('{434, 3, 0, 0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_tx",       32'(tx),         32'd1);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_in_ready", 32'(in_ready),   32'd1);
    check("rst_count",    32'(fifo_count), 32'd0);

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      apply_cfg('{vecs[v].div, vecs[v].db, vecs[v].pm, vecs[v].s2});
      src.delete();
      src.push_back(vecs[v].data);
      exp_q.delete();
      for (int j = 0; j < vecs[v].pat.len(); j++) begin
        for (int k = 0; k < vecs[v].eff; k++) exp_q.push_back(vecs[v].pat[j] == 8'h31);
      end
      run_burst($sformatf("vec%0d", v), 0, none_c);
    end

    // FIFO fill with in_valid held high: 20 bytes at 100 clocks/bit
    c = '{100, 3, 0, 0};
    apply_cfg(c);
    src.delete();
    exp_q.delete();
    for (int i = 0; i < 20; i++) src.push_back(8'(i));
    for (int i = 0; i < 20; i++) add_frame(src[i], c, i == 19);
    run_burst("fifo20", 0, none_c);
    check("fifo_accepted_before_full", 32'(acc_at_full), 32'd17);
    first0  = -1;
    stretch = 0;
    maxc    = 0;
    badc    = 0;
    foreach (rq[i]) begin
      if (first0 < 0 && rq[i] == 1'b0) first0 = i;
      if (cq[i] > maxc) maxc = cq[i];
      if (rq[i] == 1'b0 && cq[i] != 16) badc++;
    end
    if (first0 >= 0) begin
      for (int i = first0; i < rq.size() && rq[i] == 1'b0; i++) stretch++;
    end
    // Full from the 17th accept until the pop that follows frame 1 (1000 clocks + idle).
    check("fifo_full_stretch", 32'(stretch), 32'd986);
    check("fifo_max_count", 32'(maxc), 32'd16);
    check("fifo_count_when_not_ready", 32'(badc), 32'd0);

    // Config change during data bit 2 of frame 1
    c  = '{100, 3, 0, 0};
    c2 = '{50, 0, 0, 0};
    apply_cfg(c);
    src.delete();
    exp_q.delete();
    src.push_back(8'hC5);
    src.push_back(8'h1B);
    add_frame(8'hC5, c, 1'b0);
    add_frame(8'h1B, c2, 1'b1);
    run_burst("midchange", 350, c2);

    // Randomized bursts against the reference model
    for (int r = 0; r < 6; r++) begin
      c.div = $urandom_range(1, 12);
      c.db  = $urandom_range(0, 3);
      c.pm  = $urandom_range(0, 3);
      c.s2  = $urandom_range(0, 1);
      n     = $urandom_range(1, 8);
      src.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) src.push_back(8'($urandom));
      for (int i = 0; i < n; i++) add_frame(src[i], c, i == n - 1);
      apply_cfg(c);
      run_burst($sformatf("rand%0d", r), 0, none_c);
    end

    // Reset during data bit 3 of the first of three queued bytes
    c = '{20, 3, 0, 0};
    apply_cfg(c);
    src.delete();
    src.push_back(8'h81);
    src.push_back(8'h42);
    src.push_back(8'h99);
    produce();
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    repeat (90) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_tx",       32'(tx),         32'd1);
    check("post_rst_busy",     32'(busy),       32'd0);
    check("post_rst_count",    32'(fifo_count), 32'd0);
    check("post_rst_in_ready", 32'(in_ready),   32'd1);
    zeros = 0;
    bhi   = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
      if (busy !== 1'b0) bhi++;
    end
    check("post_rst_silent_tx", 32'(zeros), 32'd0);
    check("post_rst_silent_busy", 32'(bhi), 32'd0);
    src.delete();
    exp_q.delete();
    src.push_back(8'h3C);
    add_frame(8'h3C, c, 1'b1);
    run_burst("after_rst", 0, none_c);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
